vga_sync_rx: RTL and testbench

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

---
 rtl/vga_timing_pkg.sv | 17 +
 rtl/vga_sync_edge.sv | 34 +++
 rtl/vga_sync_rx.sv | 122 ++++++++++++
 tb/tb_vga_sync_rx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default VGA timing shared by receiver and transmitter, lock-state enum, saturating increment.
package vga_timing_pkg;
   localparam logic [10:0] H_SYNC_DEF  = 11'd136;
   localparam logic [10:0] H_BACK_DEF  = 11'd160;
   localparam logic [10:0] H_DISP_DEF  = 11'd1024;
   localparam logic [10:0] H_TOTAL_DEF = 11'd1344;
   localparam logic [10:0] V_SYNC_DEF  = 11'd6;
   localparam logic [10:0] V_BACK_DEF  = 11'd29;
   localparam logic [10:0] V_DISP_DEF  = 11'd768;
   localparam logic [10:0] V_TOTAL_DEF = 11'd806;

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} lock_state_e;

   function automatic logic [10:0] sat_inc(input logic [10:0] v);
      return (v == 11'h7ff) ? v : v + 11'd1;
   endfunction
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers the raw VGA inputs once and detects hsync falls and frame starts on the registered copies.
module vga_sync_edge (
   input  logic        clk,
   input  logic        rst,
   input  logic        hs_i,
   input  logic        vs_i,
   input  logic [15:0] rgb_i,
   output logic [15:0] rgb_o,
   output logic        hs_fall_o,
   output logic        frame_start_o
);
   logic        hs_q, hs_prev_q, vs_q, vs_fall_q;
   logic [15:0] rgb_q;

   assign hs_fall_o     = !hs_q && hs_prev_q;
   assign frame_start_o = hs_fall_o && !vs_q && vs_fall_q;
   assign rgb_o         = rgb_q;

   // vs_fall_q remembers vsync as seen at the previous hsync fall
   always_ff @(posedge clk)
      if (rst) begin
         hs_q      <= 1'b1;
         hs_prev_q <= 1'b1;
         vs_q      <= 1'b1;
         vs_fall_q <= 1'b1;
         rgb_q     <= '0;
      end else begin
         hs_q      <= hs_i;
         hs_prev_q <= hs_q;
         vs_q      <= vs_i;
         rgb_q     <= rgb_i;
         vs_fall_q <= hs_fall_o ? vs_q : vs_fall_q;
      end
endmodule

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: VGA timing receiver; measures line/frame lengths, locks onto conforming timing, emits active-area pixels.
// Define VGA_RX_MEAS_EN to expose the measured line and frame lengths as meas_h_total / meas_v_total.
module vga_sync_rx
   import vga_timing_pkg::*;
#(
   parameter logic [10:0] H_SYNC      = H_SYNC_DEF,
   parameter logic [10:0] H_BACK      = H_BACK_DEF,
   parameter logic [10:0] H_DISP      = H_DISP_DEF,
   parameter logic [10:0] H_TOTAL     = H_TOTAL_DEF,
   parameter logic [10:0] V_SYNC      = V_SYNC_DEF,
   parameter logic [10:0] V_BACK      = V_BACK_DEF,
   parameter logic [10:0] V_DISP      = V_DISP_DEF,
   parameter logic [10:0] V_TOTAL     = V_TOTAL_DEF,
   parameter int          LOCK_FRAMES = 2
) (
   input  logic        vga_clk,
   input  logic        rst,
   input  logic        vga_hs,
   input  logic        vga_vs,
   input  logic [15:0] vga_rgb,
   output logic [15:0] pix_data,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   output logic        pix_valid,
   output logic        frame_start,
   output logic        locked
`ifdef VGA_RX_MEAS_EN
   ,
   output logic [10:0] meas_h_total,
   output logic [10:0] meas_v_total
`endif
);
   localparam logic [10:0] H_ACT  = H_SYNC + H_BACK;
   localparam logic [10:0] H_END  = H_ACT + H_DISP;
   localparam logic [10:0] V_ACT  = V_SYNC + V_BACK;
   localparam logic [10:0] V_END  = V_ACT + V_DISP;
   localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

   logic        hs_fall, fs, line_ok, frame_ok, lines_ok_q, active, valid_d;
   logic [15:0] rgb_s1;
   logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [7:0]  good_q;
   lock_state_e state_q;

   vga_sync_edge u_edge (
      .clk          (vga_clk),
      .rst          (rst),
      .hs_i         (vga_hs),
      .vs_i         (vga_vs),
      .rgb_i        (vga_rgb),
      .rgb_o        (rgb_s1),
      .hs_fall_o    (hs_fall),
      .frame_start_o(fs)
   );

   // _d counters are the coordinates of the sample currently held in s1
   assign h_cnt_d     = hs_fall ? '0 : sat_inc(h_cnt_q);
   assign v_cnt_d     = !hs_fall ? v_cnt_q : fs ? '0 : sat_inc(v_cnt_q);
   assign line_ok     = (12'(h_cnt_q) + 12'd1) == 12'(H_TOTAL);
   assign frame_ok    = ((12'(v_cnt_q) + 12'd1) == 12'(V_TOTAL)) && lines_ok_q && line_ok;
   assign active      = h_cnt_d >= H_ACT && h_cnt_d < H_END && v_cnt_d >= V_ACT && v_cnt_d < V_END;
   assign valid_d     = state_q == LOCKED && active;
   assign locked      = state_q == LOCKED;
   assign frame_start = fs;

   always_ff @(posedge vga_clk)
      if (rst) begin
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         lines_ok_q <= 1'b0;
         pix_valid  <= 1'b0;
         pix_data   <= '0;
         pix_x      <= '0;
         pix_y      <= '0;
      end else begin
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         lines_ok_q <= !hs_fall ? lines_ok_q : fs ? 1'b1 : lines_ok_q && line_ok;
         pix_valid  <= valid_d;
         pix_data   <= valid_d ? rgb_s1 : '0;
         pix_x      <= valid_d ? h_cnt_d - H_ACT : '0;
         pix_y      <= valid_d ? v_cnt_d - V_ACT : '0;
      end

   // line check takes priority over frame check when both land on one hsync fall
   always_ff @(posedge vga_clk)
      if (rst) begin
         state_q <= SEARCH;
         good_q  <= '0;
      end else begin
         case (state_q)
            SEARCH:
               if (fs) begin
                  state_q <= VERIFY;
                  good_q  <= '0;
               end
            VERIFY:
               if ((hs_fall && !line_ok) || (fs && !frame_ok))
                  state_q <= SEARCH;
               else if (fs) begin
                  good_q <= good_q + 8'd1;
                  if (good_q + 8'd1 == LOCK_N)
                     state_q <= LOCKED;
               end
            LOCKED:
               if ((hs_fall && !line_ok) || (fs && !frame_ok) || h_cnt_q == 11'h7ff || v_cnt_q == 11'h7ff)
                  state_q <= SEARCH;
            default: state_q <= SEARCH;
         endcase
      end

`ifdef VGA_RX_MEAS_EN
   always_ff @(posedge vga_clk)
      if (rst) begin
         meas_h_total <= '0;
         meas_v_total <= '0;
      end else begin
         meas_h_total <= hs_fall ? h_cnt_q + 11'd1 : meas_h_total;
         meas_v_total <= fs ? v_cnt_q + 11'd1 : meas_v_total;
      end
`endif
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: drives a reduced-geometry VGA stream with random pixels and compares every output each cycle
// against a frame/line level model of the lock rules (VGA_RX_MEAS_EN adds the measurement checks).
module tb_vga_sync_rx;
   localparam logic [10:0] HS = 11'd3, HB = 11'd3, HD = 11'd8, HT = 11'd20;
   localparam logic [10:0] VS = 11'd1, VB = 11'd2, VD = 11'd4, VT = 11'd9;
   localparam int LF = 2;
   localparam int HA = 6, VA = 3;

   logic        vga_clk = 1'b0, rst = 1'b1, vga_hs = 1'b1, vga_vs = 1'b1;
   logic [15:0] vga_rgb = '0, pix_data;
   logic [10:0] pix_x, pix_y;
   logic        pix_valid, frame_start, locked;
`ifdef VGA_RX_MEAS_EN
   logic [10:0] meas_h_total, meas_v_total;
`endif

   int checks = 0, errors = 0;
   int m_fs = 0, pos = 0, prev_len = 0, prev_nl = 0;
   bit m_lk = 1'b0;
   logic        p_fs = 1'b0, p_v = 1'b0, p_lk = 1'b0, q_v = 1'b0, q_lk = 1'b0;
   logic [15:0] p_d = '0, q_d = '0;
   logic [10:0] p_x = '0, p_y = '0, q_x = '0, q_y = '0;

   vga_sync_rx #(
      .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_TOTAL(HT),
      .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_TOTAL(VT),
      .LOCK_FRAMES(LF)
   ) dut (
      .vga_clk    (vga_clk),
      .rst        (rst),
      .vga_hs     (vga_hs),
      .vga_vs     (vga_vs),
      .vga_rgb    (vga_rgb),
      .pix_data   (pix_data),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_valid  (pix_valid),
      .frame_start(frame_start),
      .locked     (locked)
`ifdef VGA_RX_MEAS_EN
      ,
      .meas_h_total(meas_h_total),
      .meas_v_total(meas_v_total)
`endif
   );

   always #5 vga_clk = ~vga_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // m_fs counts frame starts since the last disruption; locked once LF conforming frames follow the first
   task automatic sample(input logic hs, input logic vs, input logic [15:0] rgb, input bit ls, input bit fst,
                         input bit act, input bit r, input int h, input int v);
      bit pv, fs_e;
      pv   = m_lk && act && !r;
      fs_e = fst && !r;
      if (r) begin
         m_fs = 0;
         pos  = 0;
      end else if (ls) begin
         pos = 0;
         if (m_fs > 0 && prev_len != int'(HT)) m_fs = 0;
         else if (fst) m_fs = (m_fs == 0) ? 1 : (prev_nl == int'(VT) ? m_fs + 1 : 0);
      end else begin
         pos++;
         if (m_lk && pos == 2048) m_fs = 0;
      end
      m_lk = m_fs > LF;
      @(negedge vga_clk);
      chk("frame_start", 32'(frame_start), 32'(p_fs));
      chk("pix_valid", 32'(pix_valid), 32'(q_v));
      chk("pix_data", 32'(pix_data), 32'(q_d));
      chk("pix_x", 32'(pix_x), 32'(q_x));
      chk("pix_y", 32'(pix_y), 32'(q_y));
      chk("locked", 32'(locked), 32'(q_lk));
      vga_hs  = hs;
      vga_vs  = vs;
      vga_rgb = rgb;
      rst     = r;
      q_v  = r ? 1'b0 : p_v;
      q_d  = r ? '0 : p_d;
      q_x  = r ? '0 : p_x;
      q_y  = r ? '0 : p_y;
      q_lk = r ? 1'b0 : p_lk;
      p_fs = fs_e;
      p_v  = pv;
      p_d  = pv ? rgb : '0;
      p_x  = pv ? 11'(h - HA) : '0;
      p_y  = pv ? 11'(v - VA) : '0;
      p_lk = m_lk;
   endtask

   task automatic gen_frame(input int nl, input int bad_v, input int rst_v, input int rst_h);
      for (int v = 0; v < nl; v++) begin
         int len;
         len = (v == bad_v) ? int'(HT) - 1 : int'(HT);
         for (int h = 0; h < len; h++) begin
            bit act;
            act = h >= HA && h < HA + int'(HD) && v >= VA && v < VA + int'(VD);
            sample(h > int'(HS), v > int'(VS), act ? 16'($urandom) : 16'h0, h == 0, h == 0 && v == 0,
                   act, v == rst_v && h == rst_h, h, v);
         end
         prev_len = len;
      end
      prev_nl = nl;
   endtask

   task automatic gen_stuck(input int n);
      for (int i = 0; i < n; i++) sample(1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      prev_len = 99999;
   endtask

   initial begin
      repeat (3) @(negedge vga_clk);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_pix_data", 32'(pix_data), 32'd0);
      chk("rst_pix_x", 32'(pix_x), 32'd0);
      chk("rst_pix_y", 32'(pix_y), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      repeat (4) gen_frame(int'(VT), -1, -1, -1);
      chk("lock_nominal", 32'(locked), 32'd1);
      gen_frame(int'(VT), 4, -1, -1);
      chk("unlock_short_line", 32'(locked), 32'd0);
      repeat (3) gen_frame(int'(VT), -1, -1, -1);
      chk("relock_short_line", 32'(locked), 32'd1);
      gen_stuck(3000);
      chk("unlock_hs_stuck", 32'(locked), 32'd0);
      repeat (3) gen_frame(int'(VT), -1, -1, -1);
      chk("relock_hs_stuck", 32'(locked), 32'd1);
      gen_frame(int'(VT), -1, 4, 8);
      chk("unlock_rst", 32'(locked), 32'd0);
      repeat (3) gen_frame(int'(VT), -1, -1, -1);
      chk("relock_rst", 32'(locked), 32'd1);
      gen_frame(int'(VT) - 1, -1, -1, -1);
      gen_frame(int'(VT), -1, -1, -1);
      chk("unlock_short_frame", 32'(locked), 32'd0);
      repeat (3) gen_frame(int'(VT), -1, -1, -1);
      chk("relock_short_frame", 32'(locked), 32'd1);
`ifdef VGA_RX_MEAS_EN
      chk("meas_h_total", 32'(meas_h_total), 32'(HT));
      chk("meas_v_total", 32'(meas_v_total), 32'(VT));
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
